// File: rtl/ase_pcie_ss_dma_rd_tag_mgr.sv
// DMA read tag scheduler: allocates emulator tags, tracks outstanding DWs per tag and
// maps host-model completions back to the requesting AFU tag.
module ase_pcie_ss_dma_rd_tag_mgr #(
    parameter int MAX_OUTSTANDING    = 256,
    parameter int TAG_W              = 10,
    parameter bit EMULATE_TAG_MAPPER = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_afu_tag,
    input  logic [10:0]      req_len_dw,
    output logic [TAG_W-1:0] req_ase_tag,
    input  logic             cpl_valid,
    input  logic [TAG_W-1:0] cpl_ase_tag,
    input  logic [10:0]      cpl_len_dw,
    output logic             cplo_valid,
    output logic [TAG_W-1:0] cplo_afu_tag,
    output logic             cplo_last,
    output logic [TAG_W:0]   num_outstanding,
    output logic             err_unexp_cpl
);

    logic [MAX_OUTSTANDING-1:0] busy_q, busy_d;
    logic [TAG_W-1:0]           afu_tag_q [MAX_OUTSTANDING];
    logic [10:0]                rem_q     [MAX_OUTSTANDING];

    logic                       free_pend_q, free_pend_d;
    logic [TAG_W-1:0]           free_tag_q, free_tag_d;
    logic                       cplo_valid_q, cplo_valid_d;
    logic                       cplo_last_q, cplo_last_d;
    logic [TAG_W-1:0]           cplo_afu_tag_q, cplo_afu_tag_d;
    logic [TAG_W:0]             num_q, num_d;
    logic                       err_q, err_d;

    logic                       free_any_s;
    logic [TAG_W-1:0]           map_tag_s;
    logic                       req_hit_s;
    logic                       req_busy_s;
    logic                       cpl_busy_s;
    logic [10:0]                cpl_rem_s;
    logic [TAG_W-1:0]           cpl_afu_s;
    logic                       accept_s;
    logic                       cpl_ok_s;
    logic                       cpl_last_s;
    logic                       cpl_err_s;

    // Table lookups for the lowest free tag, the request tag and the completion tag
    always_comb begin
        free_any_s = 1'b0;
        map_tag_s  = {TAG_W{1'b0}};
        req_hit_s  = 1'b0;
        req_busy_s = 1'b0;
        cpl_busy_s = 1'b0;
        cpl_rem_s  = 11'd0;
        cpl_afu_s  = {TAG_W{1'b0}};
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            free_any_s = free_any_s | ~busy_q[i];
            map_tag_s  = busy_q[i] ? map_tag_s : TAG_W'(i);
            req_hit_s  = req_hit_s | (req_afu_tag == TAG_W'(i));
            req_busy_s = (req_afu_tag == TAG_W'(i)) ? busy_q[i] : req_busy_s;
            cpl_busy_s = (cpl_ase_tag == TAG_W'(i)) ? busy_q[i] : cpl_busy_s;
            cpl_rem_s  = (cpl_ase_tag == TAG_W'(i)) ? rem_q[i] : cpl_rem_s;
            cpl_afu_s  = (cpl_ase_tag == TAG_W'(i)) ? afu_tag_q[i] : cpl_afu_s;
        end
    end

    // Request-side handshake: remap to lowest free tag, or pass the AFU tag through
    always_comb begin
        if (EMULATE_TAG_MAPPER) begin
            req_ready   = free_any_s;
            req_ase_tag = map_tag_s;
        end else begin
            req_ready   = req_hit_s & ~req_busy_s;
            req_ase_tag = req_afu_tag;
        end
    end

    // A tag whose final completion is pending release still reads as busy with zero
    // remaining, so any further completion to it is flagged rather than matched.
    assign accept_s   = req_valid & req_ready;
    assign cpl_ok_s   = cpl_valid & cpl_busy_s & (cpl_rem_s != 11'd0) & (cpl_len_dw <= cpl_rem_s);
    assign cpl_last_s = cpl_ok_s & (cpl_len_dw == cpl_rem_s);
    assign cpl_err_s  = cpl_valid & ~cpl_ok_s;

    // Next-state for busy vector, count, completion outputs and the deferred free
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            busy_d[i] = (accept_s && (req_ase_tag == TAG_W'(i))) ? 1'b1 :
                        ((free_pend_q && (free_tag_q == TAG_W'(i))) ? 1'b0 : busy_q[i]);
        end
        num_d          = num_q + (TAG_W+1)'(accept_s) - (TAG_W+1)'(free_pend_q);
        cplo_valid_d   = cpl_ok_s;
        cplo_last_d    = cpl_last_s;
        cplo_afu_tag_d = cpl_ok_s ? cpl_afu_s : cplo_afu_tag_q;
        err_d          = err_q | cpl_err_s;
        free_pend_d    = cpl_last_s;
        free_tag_d     = cpl_last_s ? cpl_ase_tag : free_tag_q;
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q         <= {MAX_OUTSTANDING{1'b0}};
            free_pend_q    <= 1'b0;
            free_tag_q     <= {TAG_W{1'b0}};
            cplo_valid_q   <= 1'b0;
            cplo_last_q    <= 1'b0;
            cplo_afu_tag_q <= {TAG_W{1'b0}};
            num_q          <= {(TAG_W+1){1'b0}};
            err_q          <= 1'b0;
        end else begin
            busy_q         <= busy_d;
            free_pend_q    <= free_pend_d;
            free_tag_q     <= free_tag_d;
            cplo_valid_q   <= cplo_valid_d;
            cplo_last_q    <= cplo_last_d;
            cplo_afu_tag_q <= cplo_afu_tag_d;
            num_q          <= num_d;
            err_q          <= err_d;
        end
    end

    // Per-tag AFU tag and remaining-DW tables; an accept overrides a colliding completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                afu_tag_q[i] <= {TAG_W{1'b0}};
                rem_q[i]     <= 11'd0;
            end
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (accept_s && (req_ase_tag == TAG_W'(i))) begin
                    afu_tag_q[i] <= req_afu_tag;
                    rem_q[i]     <= req_len_dw;
                end else if (cpl_ok_s && (cpl_ase_tag == TAG_W'(i))) begin
                    rem_q[i]     <= rem_q[i] - cpl_len_dw;
                end
            end
        end
    end

    assign cplo_valid      = cplo_valid_q;
    assign cplo_last       = cplo_last_q;
    assign cplo_afu_tag    = cplo_afu_tag_q;
    assign num_outstanding = num_q;
    assign err_unexp_cpl   = err_q;

endmodule
